// File: rtl/text_console_master.sv
// text_console_master: turns a character byte stream into Avalon-MM writes to VGA text VRAM (cursor, wrap, newline, scroll, clear).
// Latency: printable byte writes the cycle after acceptance, back in IDLE 2 cycles after accept; unstalled scroll 1760 cycles, clear 600.
// Backpressure: CHAR_READY only in IDLE; every Avalon request holds address/data/enables until AVL_WAITREQUEST is low.
module text_console_master #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  CHAR_DATA,
  input  logic        CHAR_VALID,
  output logic        CHAR_READY,
  output logic [11:0] AVL_ADDR,
  output logic        AVL_READ,
  output logic        AVL_WRITE,
  output logic        AVL_CS,
  output logic [3:0]  AVL_BYTE_EN,
  output logic [31:0] AVL_WRITEDATA,
  input  logic [31:0] AVL_READDATA,
  input  logic        AVL_WAITREQUEST,
  output logic        BUSY,
  output logic [6:0]  CURSOR_COL,
  output logic [4:0]  CURSOR_ROW
);

  localparam int WPR    = COLS / 4;
  localparam int NWORDS = WPR * ROWS;

  // Last word copied during a scroll, first/last word of the bottom row, last VRAM word
  localparam logic [9:0] COPY_LAST = 10'(NWORDS - WPR - 1);
  localparam logic [9:0] CLR_FIRST = 10'(NWORDS - WPR);
  localparam logic [9:0] WORD_LAST = 10'(NWORDS - 1);
  localparam logic [6:0] COL_LAST  = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST  = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE_CHAR,
    SCROLL_RD,
    SCROLL_WAIT,
    SCROLL_WR,
    SCROLL_CLR,
    CLEAR
  } state_t;

  state_t      state;
  logic [9:0]  word_cnt;
  logic [11:0] cur_word;

  // VRAM word holding the character under the cursor
  assign cur_word = 12'(CURSOR_ROW) * 12'(WPR) + 12'(CURSOR_COL[6:2]);

  // Ready is forced low while reset is held so the producer never sees a false accept
  assign CHAR_READY = (state == IDLE) & ~RESET;
  assign BUSY       = (state != IDLE);
  assign AVL_CS     = AVL_READ | AVL_WRITE;

  // Main FSM: cursor bookkeeping and all Avalon request registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      word_cnt      <= '0;
      AVL_ADDR      <= '0;
      AVL_READ      <= 1'b0;
      AVL_WRITE     <= 1'b0;
      AVL_BYTE_EN   <= '0;
      AVL_WRITEDATA <= '0;
      CURSOR_COL    <= '0;
      CURSOR_ROW    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (CHAR_VALID) begin
            if (CHAR_DATA == 8'h0A) begin
              CURSOR_COL <= '0;
              if (CURSOR_ROW != ROW_LAST) begin
                CURSOR_ROW <= CURSOR_ROW + 5'd1;
              end else begin
                // Bottom row: start copying row 1 up to row 0
                state       <= SCROLL_RD;
                word_cnt    <= '0;
                AVL_ADDR    <= 12'(WPR);
                AVL_BYTE_EN <= 4'hF;
                AVL_READ    <= 1'b1;
              end
            end else if (CHAR_DATA == 8'h0C) begin
              state         <= CLEAR;
              word_cnt      <= '0;
              AVL_ADDR      <= '0;
              AVL_WRITEDATA <= '0;
              AVL_BYTE_EN   <= 4'hF;
              AVL_WRITE     <= 1'b1;
            end else begin
              // Data replicated to every lane; the byte enable picks the column
              state         <= WRITE_CHAR;
              AVL_ADDR      <= cur_word;
              AVL_BYTE_EN   <= 4'b0001 << CURSOR_COL[1:0];
              AVL_WRITEDATA <= {4{CHAR_DATA}};
              AVL_WRITE     <= 1'b1;
            end
          end
        end

        WRITE_CHAR: begin
          if (!AVL_WAITREQUEST) begin
            AVL_WRITE <= 1'b0;
            if (CURSOR_COL != COL_LAST) begin
              CURSOR_COL <= CURSOR_COL + 7'd1;
              state      <= IDLE;
            end else begin
              CURSOR_COL <= '0;
              if (CURSOR_ROW != ROW_LAST) begin
                CURSOR_ROW <= CURSOR_ROW + 5'd1;
                state      <= IDLE;
              end else begin
                state       <= SCROLL_RD;
                word_cnt    <= '0;
                AVL_ADDR    <= 12'(WPR);
                AVL_BYTE_EN <= 4'hF;
                AVL_READ    <= 1'b1;
              end
            end
          end
        end

        SCROLL_RD: begin
          if (!AVL_WAITREQUEST) begin
            AVL_READ <= 1'b0;
            state    <= SCROLL_WAIT;
          end
        end

        SCROLL_WAIT: begin
          // Slave returns data exactly one cycle after the read was accepted
          AVL_WRITEDATA <= AVL_READDATA;
          AVL_ADDR      <= {2'b00, word_cnt};
          AVL_BYTE_EN   <= 4'hF;
          AVL_WRITE     <= 1'b1;
          state         <= SCROLL_WR;
        end

        SCROLL_WR: begin
          if (!AVL_WAITREQUEST) begin
            if (word_cnt != COPY_LAST) begin
              word_cnt  <= word_cnt + 10'd1;
              AVL_ADDR  <= 12'(word_cnt) + 12'(WPR + 1);
              AVL_WRITE <= 1'b0;
              AVL_READ  <= 1'b1;
              state     <= SCROLL_RD;
            end else begin
              // Write stays asserted: blanking of the bottom row follows back to back
              word_cnt      <= CLR_FIRST;
              AVL_ADDR      <= {2'b00, CLR_FIRST};
              AVL_WRITEDATA <= '0;
              state         <= SCROLL_CLR;
            end
          end
        end

        SCROLL_CLR: begin
          if (!AVL_WAITREQUEST) begin
            if (word_cnt == WORD_LAST) begin
              AVL_WRITE <= 1'b0;
              state     <= IDLE;
            end else begin
              word_cnt <= word_cnt + 10'd1;
              AVL_ADDR <= 12'(word_cnt + 10'd1);
            end
          end
        end

        CLEAR: begin
          if (!AVL_WAITREQUEST) begin
            if (word_cnt == WORD_LAST) begin
              AVL_WRITE  <= 1'b0;
              CURSOR_COL <= '0;
              CURSOR_ROW <= '0;
              state      <= IDLE;
            end else begin
              word_cnt <= word_cnt + 10'd1;
              AVL_ADDR <= 12'(word_cnt + 10'd1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_master.sv
// tb_text_console_master: directed checks of text_console_master (print, wrap, stall, scroll, reset abort, clear).
// Latency: expectations are hand-derived per transaction at falling-edge sample points.
// Backpressure: AVL_WAITREQUEST driven directly by the bench; read data returned one cycle after acceptance.
module tb_text_console_master;

  logic        CLK;
  logic        RESET;
  logic [7:0]  CHAR_DATA;
  logic        CHAR_VALID;
  logic        CHAR_READY;
  logic [11:0] AVL_ADDR;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic        AVL_CS;
  logic [3:0]  AVL_BYTE_EN;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;
  logic        AVL_WAITREQUEST;
  logic        BUSY;
  logic [6:0]  CURSOR_COL;
  logic [4:0]  CURSOR_ROW;

  int n_checks = 0;
  int n_pass   = 0;

  text_console_master dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .CHAR_DATA       (CHAR_DATA),
    .CHAR_VALID      (CHAR_VALID),
    .CHAR_READY      (CHAR_READY),
    .AVL_ADDR        (AVL_ADDR),
    .AVL_READ        (AVL_READ),
    .AVL_WRITE       (AVL_WRITE),
    .AVL_CS          (AVL_CS),
    .AVL_BYTE_EN     (AVL_BYTE_EN),
    .AVL_WRITEDATA   (AVL_WRITEDATA),
    .AVL_READDATA    (AVL_READDATA),
    .AVL_WAITREQUEST (AVL_WAITREQUEST),
    .BUSY            (BUSY),
    .CURSOR_COL      (CURSOR_COL),
    .CURSOR_ROW      (CURSOR_ROW)
  );

  initial begin
    CLK = 1'b0;
    forever #10 CLK = ~CLK;
  end

  // Recognisable read-data pattern tagged with the source word address
  function automatic logic [31:0] pat(input int a);
    return 32'hA5C30000 + 32'(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Printable byte in the no-stall case, with the write and the cursor afterwards
  task automatic send_char(input logic [7:0] d, input int ea, input logic [3:0] eb,
                           input int ecol, input int erow);
    @(negedge CLK);
    chk("ready_before_char", 32'(CHAR_READY), 1);
    CHAR_DATA  = d;
    CHAR_VALID = 1'b1;
    @(negedge CLK);
    CHAR_VALID = 1'b0;
    chk("char_wr_req", 32'(AVL_WRITE), 1);
    chk("char_cs", 32'(AVL_CS), 1);
    chk("char_no_read", 32'(AVL_READ), 0);
    chk("char_addr", 32'(AVL_ADDR), 32'(ea));
    chk("char_be", 32'(AVL_BYTE_EN), 32'(eb));
    chk("char_data", AVL_WRITEDATA, {4{d}});
    chk("char_ready_low", 32'(CHAR_READY), 0);
    @(negedge CLK);
    chk("char_ready_back", 32'(CHAR_READY), 1);
    chk("char_busy_low", 32'(BUSY), 0);
    chk("char_col", 32'(CURSOR_COL), 32'(ecol));
    chk("char_row", 32'(CURSOR_ROW), 32'(erow));
  endtask

  // Newline that does not scroll: one cycle, no VRAM access
  task automatic send_nl(input int erow);
    @(negedge CLK);
    CHAR_DATA  = 8'h0A;
    CHAR_VALID = 1'b1;
    @(negedge CLK);
    CHAR_VALID = 1'b0;
    chk("nl_col", 32'(CURSOR_COL), 0);
    chk("nl_row", 32'(CURSOR_ROW), 32'(erow));
    chk("nl_ready", 32'(CHAR_READY), 1);
    chk("nl_busy", 32'(BUSY), 0);
    chk("nl_no_write", 32'(AVL_WRITE), 0);
  endtask

  initial begin
    int busy_cyc, first_rd, first_wr_data, last_copy, ncopy, nzero;
    int copy_err, zero_err, overlap, rd_addr, a, bc, nclr, clr_err;
    logic rd_pend;

    RESET = 1'b0;
    CHAR_DATA = 8'h00;
    CHAR_VALID = 1'b0;
    AVL_READDATA = 32'h0;
    AVL_WAITREQUEST = 1'b0;
    #1 RESET = 1'b1;
    #14;
    chk("rst_write", 32'(AVL_WRITE), 0);
    chk("rst_read", 32'(AVL_READ), 0);
    chk("rst_cs", 32'(AVL_CS), 0);
    chk("rst_addr", 32'(AVL_ADDR), 0);
    chk("rst_be", 32'(AVL_BYTE_EN), 0);
    chk("rst_wdata", AVL_WRITEDATA, 0);
    chk("rst_ready", 32'(CHAR_READY), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_col", 32'(CURSOR_COL), 0);
    chk("rst_row", 32'(CURSOR_ROW), 0);
    @(negedge CLK);
    RESET = 1'b0;

    // 'A' at (0,0): word 0, lane 0, cursor to (1,0)
    send_char(8'h41, 0, 4'b0001, 1, 0);

    // Move to (5,2), then 0xC1 at word 41 lane 1
    send_nl(1);
    send_nl(2);
    for (int i = 0; i < 5; i++) send_char(8'h61 + 8'(i), 40 + i / 4, 4'(1 << (i % 4)), i + 1, 2);
    send_char(8'hC1, 41, 4'b0010, 6, 2);

    // 'W' at (6,2) stalled for 3 cycles: request held, ready low, done 3 cycles late
    @(negedge CLK);
    CHAR_DATA = 8'h57;
    CHAR_VALID = 1'b1;
    AVL_WAITREQUEST = 1'b1;
    @(negedge CLK);
    CHAR_VALID = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("stall_write", 32'(AVL_WRITE), 1);
      chk("stall_addr", 32'(AVL_ADDR), 41);
      chk("stall_be", 32'(AVL_BYTE_EN), 32'h4);
      chk("stall_data", AVL_WRITEDATA, 32'h57575757);
      chk("stall_ready_low", 32'(CHAR_READY), 0);
      if (k == 4) AVL_WAITREQUEST = 1'b0;
      @(negedge CLK);
    end
    chk("stall_ready_back", 32'(CHAR_READY), 1);
    chk("stall_write_done", 32'(AVL_WRITE), 0);
    chk("stall_col", 32'(CURSOR_COL), 7);

    // Walk to (79,29)
    for (int r = 3; r < 30; r++) send_nl(r);
    for (int i = 0; i < 79; i++) send_char(8'h30 + 8'(i % 10), 580 + i / 4, 4'(1 << (i % 4)), i + 1, 29);

    // 'Z' at (79,29): word 599 lane 3, then full scroll
    @(negedge CLK);
    CHAR_DATA = 8'h5A;
    CHAR_VALID = 1'b1;
    @(negedge CLK);
    CHAR_VALID = 1'b0;
    chk("z_write", 32'(AVL_WRITE), 1);
    chk("z_addr", 32'(AVL_ADDR), 599);
    chk("z_be", 32'(AVL_BYTE_EN), 32'h8);
    chk("z_data", AVL_WRITEDATA, 32'h5A5A5A5A);
    busy_cyc = 1; first_rd = -1; first_wr_data = -1; last_copy = -1;
    ncopy = 0; nzero = 0; copy_err = 0; zero_err = 0; overlap = 0; rd_addr = 0;
    rd_pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      AVL_READDATA = rd_pend ? pat(rd_addr) : 32'hDEADBEEF;
      rd_pend = 1'b0;
      if (!BUSY) break;
      busy_cyc++;
      a = 32'(AVL_ADDR);
      if (AVL_READ && AVL_WRITE) overlap++;
      if (AVL_CS !== (AVL_READ | AVL_WRITE)) overlap++;
      if (AVL_READ) begin
        if (first_rd < 0) first_rd = a;
        if (a != ncopy + 20) copy_err++;
        rd_pend = 1'b1;
        rd_addr = a;
      end
      if (AVL_WRITE) begin
        if (AVL_BYTE_EN !== 4'hF) copy_err++;
        if (ncopy < 580) begin
          if (a != ncopy || AVL_WRITEDATA !== pat(ncopy + 20)) copy_err++;
          if (ncopy == 0) first_wr_data = int'(AVL_WRITEDATA);
          last_copy = a;
          ncopy++;
        end else begin
          if (a != 580 + nzero || AVL_WRITEDATA !== 32'h0) zero_err++;
          nzero++;
        end
      end
    end
    chk("scroll_busy_cycles", 32'(busy_cyc), 1761);
    chk("scroll_first_read", 32'(first_rd), 20);
    chk("scroll_first_copy_data", 32'(first_wr_data), pat(20));
    chk("scroll_last_copy_addr", 32'(last_copy), 579);
    chk("scroll_copies", 32'(ncopy), 580);
    chk("scroll_copy_errors", 32'(copy_err), 0);
    chk("scroll_zero_writes", 32'(nzero), 20);
    chk("scroll_zero_errors", 32'(zero_err), 0);
    chk("scroll_overlap", 32'(overlap), 0);
    chk("scroll_col", 32'(CURSOR_COL), 0);
    chk("scroll_row", 32'(CURSOR_ROW), 29);
    chk("scroll_ready", 32'(CHAR_READY), 1);

    // Newline at the bottom starts another scroll; reset aborts it midway
    @(negedge CLK);
    CHAR_DATA = 8'h0A;
    CHAR_VALID = 1'b1;
    @(negedge CLK);
    CHAR_VALID = 1'b0;
    chk("nl_scroll_busy", 32'(BUSY), 1);
    chk("nl_scroll_read", 32'(AVL_READ), 1);
    chk("nl_scroll_addr", 32'(AVL_ADDR), 20);
    repeat (100) @(negedge CLK);
    chk("mid_scroll_busy", 32'(BUSY), 1);
    #3 RESET = 1'b1;
    #1;
    chk("abort_write", 32'(AVL_WRITE), 0);
    chk("abort_read", 32'(AVL_READ), 0);
    chk("abort_cs", 32'(AVL_CS), 0);
    chk("abort_addr", 32'(AVL_ADDR), 0);
    chk("abort_be", 32'(AVL_BYTE_EN), 0);
    chk("abort_wdata", AVL_WRITEDATA, 0);
    chk("abort_busy", 32'(BUSY), 0);
    chk("abort_ready", 32'(CHAR_READY), 0);
    chk("abort_row", 32'(CURSOR_ROW), 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("post_abort_ready", 32'(CHAR_READY), 1);
    chk("post_abort_busy", 32'(BUSY), 0);
    chk("post_abort_req", 32'(AVL_CS), 0);
    send_char(8'h42, 0, 4'b0001, 1, 0);

    // Move to (10,7), then clear screen
    for (int r = 1; r <= 7; r++) send_nl(r);
    for (int i = 0; i < 10; i++) send_char(8'h41 + 8'(i), 140 + i / 4, 4'(1 << (i % 4)), i + 1, 7);
    @(negedge CLK);
    CHAR_DATA = 8'h0C;
    CHAR_VALID = 1'b1;
    @(negedge CLK);
    CHAR_VALID = 1'b0;
    bc = 0; nclr = 0; clr_err = 0;
    for (int c = 0; c < 1000; c++) begin
      if (!BUSY) break;
      bc++;
      if (AVL_READ) clr_err++;
      if (AVL_WRITE) begin
        if (32'(AVL_ADDR) != nclr || AVL_WRITEDATA !== 32'h0 || AVL_BYTE_EN !== 4'hF) clr_err++;
        nclr++;
      end else begin
        clr_err++;
      end
      @(negedge CLK);
    end
    chk("clear_busy_cycles", 32'(bc), 600);
    chk("clear_writes", 32'(nclr), 600);
    chk("clear_errors", 32'(clr_err), 0);
    chk("clear_col", 32'(CURSOR_COL), 0);
    chk("clear_row", 32'(CURSOR_ROW), 0);
    chk("clear_ready", 32'(CHAR_READY), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
